// File: rtl/channel_arbiter.sv
// Round-robin arbiter that frames one requester's 9-bit word with even parity onto a shared channel,
// holding it HOLD clocks and then idling GAP clocks; registered outputs, grant is a one-clock pulse.
module channel_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req,
  input  logic [9*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]       grant,
  output logic [9:0]            chan_out,
  output logic                  chan_valid,
  output logic [$clog2(NREQ)-1:0] src_id,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);
  localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LD  = 8'(GAP - 1);
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic [7:0]      gap_cnt, gap_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [9:0]      chan_nxt;
  logic            valid_nxt;
  logic [IW-1:0]   src_nxt;
  logic            busy_nxt;
  logic            start;
  logic [IW-1:0]   win;
  logic [8:0]      win_data;
  int              idx;
  logic            found;

  // First pending requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last) + off) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_data = req_data[9*int'(win) +: 9];

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    last_nxt  = last;
    grant_nxt = '0;
    chan_nxt  = chan_out;
    valid_nxt = chan_valid;
    src_nxt   = src_id;
    busy_nxt  = busy;
    start     = 1'b0;

    case (state)
      ST_IDLE: begin
        start     = enable && (|req);
        chan_nxt  = '0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
      ST_SEND: begin
        if (hold_cnt == 8'd0) begin
          chan_nxt  = '0;
          valid_nxt = 1'b0;
          if (HAS_GAP) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LD;
          end else begin
            // With no gap the last SEND clock arbitrates, giving back-to-back words.
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            start     = enable && (|req);
          end
        end else begin
          hold_nxt = hold_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (start) begin
      state_nxt      = ST_SEND;
      hold_nxt       = HOLD_LD;
      last_nxt       = win;
      grant_nxt[win] = 1'b1;
      chan_nxt       = {^win_data, win_data};
      valid_nxt      = 1'b1;
      src_nxt        = win;
      busy_nxt       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      last       <= IW'(NREQ - 1);
      grant      <= '0;
      chan_out   <= '0;
      chan_valid <= 1'b0;
      src_id     <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      gap_cnt    <= gap_nxt;
      last       <= last_nxt;
      grant      <= grant_nxt;
      chan_out   <= chan_nxt;
      chan_valid <= valid_nxt;
      src_id     <= src_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench: default-parameter arbiter plus a HOLD=1/GAP=0 instance for back-to-back words.
module tb_channel_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        enable;
  logic [3:0]  req, req_b;
  logic [35:0] req_data, req_data_b;
  logic [3:0]  grant, grant_b;
  logic [9:0]  chan_out, chan_out_b;
  logic        chan_valid, chan_valid_b;
  logic [1:0]  src_id, src_id_b;
  logic        busy, busy_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  channel_arbiter #(.NREQ(4), .HOLD(4), .GAP(1)) dut (
    .clk(clk), .clr(clr), .enable(enable), .req(req), .req_data(req_data),
    .grant(grant), .chan_out(chan_out), .chan_valid(chan_valid),
    .src_id(src_id), .busy(busy)
  );

  channel_arbiter #(.NREQ(4), .HOLD(1), .GAP(0)) dut_b2b (
    .clk(clk), .clr(clr), .enable(enable), .req(req_b), .req_data(req_data_b),
    .grant(grant_b), .chan_out(chan_out_b), .chan_valid(chan_valid_b),
    .src_id(src_id_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word from requester idx; returns to IDLE afterwards.
  task automatic send_word(input int idx, input logic [8:0] data, input logic [9:0] exp_chan);
    req_data[9*idx +: 9] = data;
    req = 4'b0001 << idx;
    tick();
    check("word_grant", 32'(grant), 32'(4'b0001 << idx));
    check("word_chan", 32'(chan_out), 32'(exp_chan));
    req = 4'b0000;
    repeat (5) tick();
  endtask

  logic [9:0] rr_chan [4];

  initial begin
    clr = 1'b1; enable = 1'b1; req = 4'hF; req_b = 4'h0;
    req_data = '0; req_data_b = '0;
    repeat (2) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_chan", 32'(chan_out), 32'h000);
    check("rst_valid", 32'(chan_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_src", 32'(src_id), 32'h0);

    // Single word from requester 2, default HOLD=4 GAP=1
    clr = 1'b0; req = 4'b0100; req_data[18 +: 9] = 9'h003;
    tick();
    check("single_grant_k", 32'(grant), 32'h4);
    check("single_chan_k", 32'(chan_out), 32'h003);
    check("single_src_k", 32'(src_id), 32'h2);
    check("single_busy_k", 32'(busy), 32'h1);
    req = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("single_grant_hold", 32'(grant), 32'h0);
      check("single_chan_hold", 32'(chan_out), 32'h003);
      check("single_valid_hold", 32'(chan_valid), 32'h1);
    end
    tick();
    check("single_valid_k4", 32'(chan_valid), 32'h0);
    check("single_chan_k4", 32'(chan_out), 32'h000);
    check("single_busy_k4", 32'(busy), 32'h1);
    req = 4'b0100;
    tick();
    check("single_grant_k5", 32'(grant), 32'h0);
    check("single_busy_k5", 32'(busy), 32'h0);
    tick();
    check("single_grant_k6", 32'(grant), 32'h4);
    req = 4'b0000;
    repeat (5) tick();

    // Parity framing
    send_word(0, 9'h1FF, 10'h3FF);
    send_word(0, 9'h101, 10'h101);
    send_word(0, 9'h001, 10'h201);

    // Round-robin with all requesters held
    clr = 1'b1; tick(); clr = 1'b0;
    req_data = {9'h014, 9'h013, 9'h012, 9'h011};
    rr_chan[0] = 10'h011; rr_chan[1] = 10'h012; rr_chan[2] = 10'h213; rr_chan[3] = 10'h014;
    req = 4'hF;
    for (int w = 0; w < 6; w++) begin
      tick();
      check("rr_grant", 32'(grant), 32'(4'b0001 << (w % 4)));
      check("rr_chan", 32'(chan_out), 32'(rr_chan[w % 4]));
      check("rr_src", 32'(src_id), 32'(w % 4));
      tick();
      check("rr_grant_pulse", 32'(grant), 32'h0);
      repeat (4) tick();
    end
    req = 4'h0;
    repeat (5) tick();

    // enable dropped during SEND clock 2
    req = 4'b0001;
    tick();
    check("en_grant", 32'(grant), 32'h1);
    tick();
    enable = 1'b0;
    tick();
    check("en_valid3", 32'(chan_valid), 32'h1);
    tick();
    check("en_valid4", 32'(chan_valid), 32'h1);
    check("en_chan4", 32'(chan_out), 32'h011);
    tick();
    check("en_valid5", 32'(chan_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_no_grant", 32'(grant), 32'h0);
    end
    enable = 1'b1;
    tick();
    check("en_regrant", 32'(grant), 32'h1);
    req = 4'b0000;
    repeat (5) tick();

    // clr during SEND clock 2
    req = 4'b0010;
    tick();
    check("clr_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    clr = 1'b1;
    tick();
    check("clr_grant_rst", 32'(grant), 32'h0);
    check("clr_chan_rst", 32'(chan_out), 32'h000);
    check("clr_valid_rst", 32'(chan_valid), 32'h0);
    check("clr_busy_rst", 32'(busy), 32'h0);
    check("clr_src_rst", 32'(src_id), 32'h0);
    clr = 1'b0; req = 4'hF;
    tick();
    check("clr_first_winner", 32'(grant), 32'h1);
    check("clr_first_chan", 32'(chan_out), 32'h011);
    req = 4'h0;
    repeat (5) tick();

    // Back-to-back on the HOLD=1 GAP=0 instance
    req_data_b = {9'h0, 9'h0, 9'h007, 9'h005};
    req_b = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b2b_grant", 32'(grant_b), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("b2b_chan", 32'(chan_out_b), (i % 2 == 0) ? 32'h005 : 32'h207);
      check("b2b_valid", 32'(chan_valid_b), 32'h1);
    end
    req_b = 4'b0000;
    tick();
    check("b2b_idle_valid", 32'(chan_valid_b), 32'h0);
    check("b2b_idle_busy", 32'(busy_b), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/channel_arbiter.md
Name: channel_arbiter

Overview:
- Sequences and shares the serial-word channel between NREQ requesters.
- Selects one pending requester round-robin and frames its 9-bit word with an even-parity bit into the 10-bit channel word that feeds the receiver.
- Holds each word stable for HOLD clocks, then idles the channel for GAP clocks, so the receiver decodes correctly at the faster clock rates.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- HOLD, 4, clocks each word is driven with chan_valid high; legal range 1..255.
- GAP, 1, idle clocks after each word; legal range 0..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- clr  input  1  synchronous active-high reset.
- enable  input  1  high permits starting new words.
- req  input  NREQ  per-requester word pending; level, bit i for requester i.
- req_data  input  9*NREQ  requester i's word on bits [9i+8:9i].
- grant  output  NREQ  one-hot one-clock pulse: word of requester i accepted.
- chan_out  output  10  channel word to receiver.
- chan_valid  output  1  high while chan_out carries a word.
- src_id  output  clog2(NREQ)  index of requester currently on channel.
- busy  output  1  high in SEND or GAP.

Behaviour:
- Reset: clk and clr only; synchronous, active-high.
  - When clr is sampled high: state=IDLE; grant=0, chan_out=10'b0, chan_valid=0, src_id=0, busy=0, hold/gap counters=0, round-robin pointer last=NREQ-1, so requester 0 wins first.
- Outputs are registered.
- Framing: chan_out[8:0] = data, chan_out[9] = ^data (total ones even). Idle chan_out = 10'b0.
- IDLE state:
  - If enable & |req is sampled at edge k, the winner is the first set req bit searching last+1, last+2, … modulo NREQ.
  - At edge k: latch req_data of the winner into chan_out with parity, chan_valid=1, src_id=winner, grant[winner]=1 for exactly one clock, busy=1, last=winner, hold counter loaded, state→SEND.
  - Otherwise remain in IDLE with outputs idle.
- SEND state:
  - chan_out is stable for exactly HOLD clocks of chan_valid=1, including the grant clock.
  - Changes to req_data or req during SEND are ignored.
  - After HOLD clocks: chan_out=0, chan_valid=0. If GAP>0, state→GAP; else state→IDLE and busy=0.
- GAP state:
  - GAP clocks with chan_valid=0, chan_out=0, busy=1; then state→IDLE and busy=0.
- Arbitration timing:
  - Arbitration occurs only in IDLE. The first IDLE clock after a word still arbitrates, so minimum word period = HOLD+GAP+1 clocks.
  - Exception: when GAP=0, the final SEND clock arbitrates directly (back-to-back). Period then = HOLD clocks.
- Request semantics:
  - A requester must drop req within the clock after its grant pulse. A req still high when next sampled is a new word.
- enable deasserted mid-word: current SEND/GAP completes normally; no new arbitration while enable=0.
- clr mid-word: outputs go to reset values at that edge; the word is abandoned and no grant is reissued.
- Simultaneous req from all requesters: strict rotation, one grant per word, no requester starved. Max wait = (NREQ-1) word periods.
- src_id holds its last value in IDLE/GAP and is meaningful only with chan_valid.
- Internal counters are 8-bit; no wrap occurs within legal parameter ranges.

Test Plan:
- Reset: drive clr=1 for 2 clocks with req=4'hF → grant=0, chan_out=10'h000, chan_valid=0, busy=0, src_id=0.
- Single word, defaults: req=4'b0100 with data2=9'h003 sampled at edge k → grant=4'b0100 at k only; chan_out=10'h003, chan_valid=1, src_id=2 for edges k..k+3; idle at k+4; next grant no earlier than k+6.
- Parity: data0=9'h1FF → chan_out=10'h3FF; data0=9'h101 → 10'h101; data0=9'h001 → 10'h201.
- Round-robin: req=4'hF held, distinct data per requester → grant order 0,1,2,3,0,1 with chan_out matching each; no repeat before rotation completes.
- Back-to-back, HOLD=1, GAP=0: requesters 0 and 1 held high → a grant every clock alternating 0,1; chan_valid continuously 1.
- enable and clr mid-word:
  - enable→0 at SEND clock 2 → word still held 4 clocks, then no new grant until enable=1.
  - Separately, clr at SEND clock 2 → next clock all outputs at reset values; after release, requester 0 wins first.
